// File: rtl/sao_stat_acc_if.sv
// Bundles the sao_stat_acc input group stream and the result stream.
//   start_i/val_i/cat_i/num_i/diff_i/end_i : per-cycle sample-group input
//   out_val_o/out_rdy_i                    : result valid/ready handshake
//   out_cat_o/out_cnt_o/out_sum_o/out_last_o : presented per-category result
// Modports: slave = accumulator side, master = surrounding pipeline side.
interface sao_stat_acc_if #(
    parameter int NUM_CAT = 4,
    parameter int CNT_W   = 13,
    parameter int SUM_W   = 18
);
    localparam int CAT_W = (NUM_CAT > 1) ? $clog2(NUM_CAT) : 1;

    logic             start_i;
    logic             val_i;
    logic [CAT_W-1:0] cat_i;
    logic [3:0]       num_i;
    logic [9:0]       diff_i;
    logic             end_i;
    logic             out_val_o;
    logic             out_rdy_i;
    logic [CAT_W-1:0] out_cat_o;
    logic [CNT_W-1:0] out_cnt_o;
    logic [SUM_W-1:0] out_sum_o;
    logic             out_last_o;

    modport slave (
        input  start_i, val_i, cat_i, num_i, diff_i, end_i, out_rdy_i,
        output out_val_o, out_cat_o, out_cnt_o, out_sum_o, out_last_o
    );

    modport master (
        output start_i, val_i, cat_i, num_i, diff_i, end_i, out_rdy_i,
        input  out_val_o, out_cat_o, out_cnt_o, out_sum_o, out_last_o
    );
endinterface

// File: rtl/sao_stat_acc.sv
// Per-CTU SAO statistics accumulator. Accumulates a saturating sample count
// and a saturating signed difference sum per category over one CTU, then
// streams the per-category totals out over a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : input group stream and result stream (sao_stat_acc_if.slave)
//   busy_o   : high while accumulating or dumping
module sao_stat_acc #(
    parameter int NUM_CAT = 4,
    parameter int CNT_W   = 13,
    parameter int SUM_W   = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    sao_stat_acc_if.slave        bus,
    output logic                 busy_o
);
    localparam int CAT_W = (NUM_CAT > 1) ? $clog2(NUM_CAT) : 1;
    localparam logic [CAT_W-1:0] LAST_CAT = CAT_W'(NUM_CAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q [NUM_CAT];
    logic [CNT_W-1:0] cnt_d [NUM_CAT];
    logic [SUM_W-1:0] sum_q [NUM_CAT];
    logic [SUM_W-1:0] sum_d [NUM_CAT];

    logic             out_val_q,  out_val_d;
    logic [CAT_W-1:0] out_cat_q,  out_cat_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic [SUM_W-1:0] out_sum_q,  out_sum_d;
    logic             out_last_q, out_last_d;
    logic [CAT_W-1:0] nxt_cat;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [3:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-3){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // One guard bit: a sign mismatch between the two top bits is overflow.
    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] a,
                                                 input logic [9:0] d);
        logic [SUM_W:0] s;
        s = {a[SUM_W-1], a} + {{(SUM_W-9){d[9]}}, d};
        if (s[SUM_W] != s[SUM_W-1])
            return s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        return s[SUM_W-1:0];
    endfunction

    assign nxt_cat = out_cat_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        out_val_d  = out_val_q;
        out_cat_d  = out_cat_q;
        out_cnt_d  = out_cnt_q;
        out_sum_d  = out_sum_q;
        out_last_d = out_last_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    for (int unsigned i = 0; i < NUM_CAT; i++) begin
                        cnt_d[i] = '0;
                        sum_d[i] = '0;
                    end
                    state_d = ACC;
                end
            end
            ACC: begin
                if (bus.start_i) begin
                    for (int unsigned i = 0; i < NUM_CAT; i++) begin
                        cnt_d[i] = '0;
                        sum_d[i] = '0;
                    end
                end else begin
                    if (bus.val_i) begin
                        cnt_d[bus.cat_i] = sat_cnt(cnt_q[bus.cat_i], bus.num_i);
                        sum_d[bus.cat_i] = sat_sum(sum_q[bus.cat_i], bus.diff_i);
                    end
                    // Category 0 is loaded from the post-update values so a
                    // group arriving with end_i is visible in the first result.
                    if (bus.end_i) begin
                        state_d    = DUMP;
                        out_val_d  = 1'b1;
                        out_cat_d  = '0;
                        out_cnt_d  = cnt_d[0];
                        out_sum_d  = sum_d[0];
                        out_last_d = (NUM_CAT == 1);
                    end
                end
            end
            DUMP: begin
                if (out_val_q && bus.out_rdy_i) begin
                    if (out_last_q) begin
                        state_d    = IDLE;
                        out_val_d  = 1'b0;
                        out_last_d = 1'b0;
                        out_cat_d  = '0;
                        out_cnt_d  = '0;
                        out_sum_d  = '0;
                    end else begin
                        out_cat_d  = nxt_cat;
                        out_cnt_d  = cnt_q[nxt_cat];
                        out_sum_d  = sum_q[nxt_cat];
                        out_last_d = (nxt_cat == LAST_CAT);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '{default: '0};
            sum_q      <= '{default: '0};
            out_val_q  <= 1'b0;
            out_cat_q  <= '0;
            out_cnt_q  <= '0;
            out_sum_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            out_val_q  <= out_val_d;
            out_cat_q  <= out_cat_d;
            out_cnt_q  <= out_cnt_d;
            out_sum_q  <= out_sum_d;
            out_last_q <= out_last_d;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign bus.out_val_o  = out_val_q;
    assign bus.out_cat_o  = out_cat_q;
    assign bus.out_cnt_o  = out_cnt_q;
    assign bus.out_sum_o  = out_sum_q;
    assign bus.out_last_o = out_last_q;
endmodule

// File: tb/tb_sao_stat_acc.sv
// Testbench for sao_stat_acc: directed group streams, expected per-category
// totals queued at stimulus time and popped by a monitor on each handshake.
module tb_sao_stat_acc;
    logic clk;
    logic rst;
    logic busy_o;

    sao_stat_acc_if #(.NUM_CAT(4), .CNT_W(13), .SUM_W(18)) bus ();

    sao_stat_acc #(.NUM_CAT(4), .CNT_W(13), .SUM_W(18)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .busy_o (busy_o)
    );

    typedef struct {
        int cat;
        int cnt;
        int sum;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_hs  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed on every cycle with valid and ready high.
    always @(negedge clk) begin
        if (!rst && bus.out_val_o && bus.out_rdy_i) begin
            exp_t e;
            n_hs++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("res_cat",  longint'(bus.out_cat_o), e.cat);
                check("res_cnt",  longint'(bus.out_cnt_o), e.cnt);
                check("res_sum",  longint'($signed(bus.out_sum_o)), e.sum);
                check("res_last", longint'(bus.out_last_o), e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit v, input int c, input int n,
                         input int d, input bit e);
        bus.start_i = st;
        bus.val_i   = v;
        bus.cat_i   = 2'(c);
        bus.num_i   = 4'(n);
        bus.diff_i  = 10'(d);
        bus.end_i   = e;
        tick();
        bus.start_i = 1'b0;
        bus.val_i   = 1'b0;
        bus.cat_i   = '0;
        bus.num_i   = '0;
        bus.diff_i  = '0;
        bus.end_i   = 1'b0;
    endtask

    task automatic push(input int c, input int n, input int s, input int l);
        exp_t e;
        e.cat = c; e.cnt = n; e.sum = s; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_zero_dump();
        for (int i = 0; i < 4; i++) push(i, 0, 0, (i == 3) ? 1 : 0);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy_o && k < 50) begin
            tick();
            k++;
        end
        check(name, longint'(busy_o), 0);
    endtask

    task automatic basic_groups();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 15, 31, 0);
        drive(0, 1, 1, 8, -20, 0);
        drive(0, 1, 0, 1, -5, 0);
    endtask

    task automatic push_basic();
        push(0, 16, 26, 0);
        push(1, 8, -20, 0);
        push(2, 0, 0, 0);
        push(3, 15, 0, 1);
    endtask

    initial begin
        int hs0;
        rst = 1'b1;
        bus.start_i = 0; bus.val_i = 0; bus.cat_i = '0; bus.num_i = '0;
        bus.diff_i = '0; bus.end_i = 0; bus.out_rdy_i = 0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", longint'(busy_o), 0);
        check("rst_val",  longint'(bus.out_val_o), 0);
        check("rst_last", longint'(bus.out_last_o), 0);
        check("rst_cat",  longint'(bus.out_cat_o), 0);
        check("rst_cnt",  longint'(bus.out_cnt_o), 0);
        check("rst_sum",  longint'(bus.out_sum_o), 0);

        // Basic accumulation, end_i coincident with the last group
        bus.out_rdy_i = 1'b1;
        push_basic();
        hs0 = n_hs;
        basic_groups();
        check("acc_busy", longint'(busy_o), 1);
        drive(0, 1, 3, 15, 0, 1);
        check("first_lat_val", longint'(bus.out_val_o), 1);
        check("first_lat_cat", longint'(bus.out_cat_o), 0);
        wait_idle("basic_idle");
        check("basic_val_after", longint'(bus.out_val_o), 0);
        check("basic_last_after", longint'(bus.out_last_o), 0);
        check("basic_results", n_hs - hs0, 4);

        // Backpressure on category 1
        push_basic();
        hs0 = n_hs;
        basic_groups();
        drive(0, 1, 3, 15, 0, 1);
        tick();
        bus.out_rdy_i = 1'b0;
        check("bp_cat_first", longint'(bus.out_cat_o), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_val", longint'(bus.out_val_o), 1);
            check("bp_hold_cat", longint'(bus.out_cat_o), 1);
            check("bp_hold_cnt", longint'(bus.out_cnt_o), 8);
            check("bp_hold_sum", longint'($signed(bus.out_sum_o)), -20);
        end
        bus.out_rdy_i = 1'b1;
        tick();
        check("bp_advance", longint'(bus.out_cat_o), 2);
        wait_idle("bp_idle");
        check("bp_results", n_hs - hs0, 4);

        // Negative saturation
        push(0, 0, 0, 0);
        push(1, 0, 0, 0);
        push(2, 4500, -131072, 0);
        push(3, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) drive(0, 1, 2, 15, -512, (i == 299));
        wait_idle("negsat_idle");

        // Positive saturation
        push(0, 0, 0, 0);
        push(1, 0, 0, 0);
        push(2, 4500, 131071, 0);
        push(3, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) drive(0, 1, 2, 15, 511, (i == 299));
        wait_idle("possat_idle");

        // Re-start in ACC discards everything including the coincident group
        push_zero_dump();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 5, 7, 0);
        drive(0, 1, 1, 6, -9, 0);
        drive(0, 1, 2, 7, 100, 0);
        drive(0, 1, 3, 8, -100, 0);
        drive(0, 1, 0, 9, 1, 0);
        drive(1, 1, 0, 4, 3, 0);
        check("restart_busy", longint'(busy_o), 1);
        drive(0, 0, 0, 0, 0, 1);
        wait_idle("restart_idle");

        // Ignored inputs in IDLE and DUMP
        drive(0, 1, 1, 7, 100, 1);
        drive(0, 1, 1, 7, 100, 1);
        check("idle_ign_busy", longint'(busy_o), 0);
        check("idle_ign_val", longint'(bus.out_val_o), 0);
        push(0, 0, 0, 0);
        push(1, 2, 10, 0);
        push(2, 0, 0, 0);
        push(3, 0, 0, 1);
        bus.out_rdy_i = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 2, 10, 1);
        drive(1, 1, 1, 5, 5, 1);
        drive(1, 1, 0, 5, 5, 1);
        check("dump_ign_cat", longint'(bus.out_cat_o), 0);
        check("dump_ign_busy", longint'(busy_o), 1);
        bus.out_rdy_i = 1'b1;
        wait_idle("dump_ign_idle");

        // Reset mid-DUMP
        push(0, 3, -7, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 3, -7, 0);
        drive(0, 1, 1, 4, 9, 1);
        tick();
        bus.out_rdy_i = 1'b0;
        check("mid_cat1", longint'(bus.out_cat_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_val",  longint'(bus.out_val_o), 0);
        check("mid_rst_busy", longint'(busy_o), 0);
        check("mid_rst_cnt",  longint'(bus.out_cnt_o), 0);
        check("mid_rst_sum",  longint'(bus.out_sum_o), 0);
        bus.out_rdy_i = 1'b1;
        push_zero_dump();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        wait_idle("post_rst_idle");

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
